// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared Kyber constants and pk_encoder FSM state type
package kyber_pkg;

  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int KYBER_K = 3;
  localparam int PK_BITS = KYBER_K * 3072 + 256;
  localparam int CNT_W   = 10;

  typedef enum logic [1:0] {
    PK_IDLE,
    PK_LOAD,
    PK_HASH,
    PK_DONE
  } pk_state_e;

endpackage

// File: rtl/coeff_csub.sv
// rtl/coeff_csub.sv - conditional subtraction of q from a 12-bit coefficient
module coeff_csub
  import kyber_pkg::*;
(
  input  logic [11:0] coeff,
  output logic [11:0] coeff_red
);

  localparam logic [11:0] Q12 = 12'(KYBER_Q);

  assign coeff_red = (coeff >= Q12) ? (coeff - Q12) : coeff;

endmodule

// File: rtl/pk_encoder.sv
// rtl/pk_encoder.sv - Kyber public-key ByteEncode12 packer with H(pk) capture; PK_COEFF_REDUCE_EN enables coefficient reduction
module pk_encoder #(
  parameter int KYBER_K = kyber_pkg::KYBER_K,
  parameter int PK_BITS = kyber_pkg::PK_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [255:0]       rho,
  input  logic [11:0]        coeff_in,
  input  logic               coeff_valid,
  output logic               coeff_ready,
  output logic [PK_BITS-1:0] pk,
  output logic [13:0]        pk_len,
  output logic               hash_enable,
  input  logic               hash_done,
  input  logic [255:0]       hash_digest,
  output logic [255:0]       hpk,
  output logic               busy,
  output logic               pk_done
);
  import kyber_pkg::*;

  localparam int              NCOEFF = KYBER_K * KYBER_N;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NCOEFF - 1);

  pk_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [PK_BITS-1:0] pk_q;
  logic [255:0]       hpk_q;
  logic [11:0]        coeff_w;
  logic               xfer;

`ifdef PK_COEFF_REDUCE_EN
  coeff_csub u_coeff_csub (
    .coeff     (coeff_in),
    .coeff_red (coeff_w)
  );
`else
  assign coeff_w = coeff_in;
`endif

  assign xfer = coeff_valid && (state_q == PK_LOAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= PK_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    coeff_ready = 1'b0;
    hash_enable = 1'b0;
    busy        = 1'b1;
    pk_done     = 1'b0;
    case (state_q)
      PK_IDLE: begin
        busy = 1'b0;
        if (start) state_d = PK_LOAD;
      end
      PK_LOAD: begin
        coeff_ready = 1'b1;
        if (xfer && cnt_q == LAST) state_d = PK_HASH;
      end
      PK_HASH: begin
        hash_enable = 1'b1;
        if (hash_done) state_d = PK_DONE;
      end
      PK_DONE: begin
        pk_done = 1'b1;
        state_d = PK_IDLE;
      end
      default: state_d = PK_IDLE;
    endcase
  end

  // Coefficients land little-endian at 12-bit stride; rho sits above the polynomials.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      pk_q  <= '0;
      hpk_q <= '0;
    end else begin
      if (state_q == PK_IDLE && start) begin
        cnt_q                  <= '0;
        pk_q[PK_BITS-1 -: 256] <= rho;
      end
      if (xfer) begin
        pk_q[12*int'(cnt_q) +: 12] <= coeff_w;
        cnt_q                      <= cnt_q + 1'b1;
      end
      if (state_q == PK_HASH && hash_done) hpk_q <= hash_digest;
    end
  end

  assign pk     = pk_q;
  assign hpk    = hpk_q;
  assign pk_len = 14'(PK_BITS);

endmodule
